// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA fill a small FIFO that a
// serializer drains onto tx. STATUS loads are combinational.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_busy
);
  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (low) for CLKS_PER_BIT cycles
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high); chains straight into START if more bytes wait
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  state_t        state, state_nx;
  logic [BW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;

  logic sel, full, empty, baud_tc, push, push_ok, pop, status_wr;
  logic unused_bits;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign baud_tc   = (baud_cnt == BAUD_TC);
  assign push      = wr_en && sel && (addr[3:2] == 2'b00);
  assign status_wr = wr_en && sel && (addr[3:2] == 2'b01);
  assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_tc));
  // A push into a full FIFO survives only if a pop frees the slot at the same edge.
  assign push_ok   = push && (!full || pop);
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  always_comb begin
    rdata = 32'h0;
    if (rd_en && sel && addr[3:2] == 2'b01)
      rdata = {28'h0, overflow, tx_busy, empty, full};
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + 1'b1;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    case (state)
      IDLE: begin
        baud_nx = '0;
        if (pop) begin
          shift_nx = mem[rd_ptr];
          state_nx = START;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_nx  = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_nx = '0;
          if (bit_cnt == 3'd7) begin
            state_nx = STOP;
          end else begin
            shift_nx = {1'b0, shift[7:1]};
            bit_nx   = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_nx = '0;
          if (pop) begin
            shift_nx = mem[rd_ptr];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // tx is registered, so it is derived from the state being entered.
  always_comb begin
    tx_nx = 1'b1;
    if (state_nx == START)     tx_nx = 1'b0;
    else if (state_nx == DATA) tx_nx = shift_nx[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      tx       <= tx_nx;
      tx_busy  <= (state_nx != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (status_wr && wdata[3])
        overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized bench for uart_tx_mmio checked against a frame-level model
// (byte queue plus position within the current 10-bit frame).
module tb_uart_tx_mmio;
  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] rdata;
  logic        tx, tx_busy;

  int total = 0, bad = 0;

  logic [7:0] q[$];
  logic       m_busy = 1'b0, m_ovf = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = '0;
  logic [31:0] last_rdata;

  uart_tx_mmio #(.BASE_ADDR(32'h0000_1000), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .rdata(rdata), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {28'h0, m_ovf, m_busy, q.size() == 0, q.size() == D};
  endfunction

  function automatic logic m_tx();
    if (!m_busy)          return 1'b1;
    if (m_t < C)          return 1'b0;
    if (m_t < 9 * C)      return m_cur[m_t / C - 1];
    return 1'b1;
  endfunction

  task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic rb);
    logic sel, push, pop, full_pre;
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d; rst = rb;
    #1;
    sel = (a[31:4] == 28'h0000_100);
    last_rdata = rdata;
    chk("rdata", rdata, (r && sel && a[3:2] == 2'd1) ? m_status() : 32'h0);
    @(posedge clk);
    if (!rb) begin
      q.delete(); m_busy = 1'b0; m_ovf = 1'b0; m_t = 0;
    end else begin
      push     = w && sel && a[3:2] == 2'd0;
      full_pre = (q.size() == D);
      pop      = (q.size() > 0) && (!m_busy || m_t == FRAME - 1);
      if (pop) begin
        m_cur = q.pop_front(); m_busy = 1'b1; m_t = 0;
      end else if (m_busy) begin
        if (m_t == FRAME - 1) m_busy = 1'b0;
        else m_t++;
      end
      if (push) begin
        if (!full_pre || pop) q.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end else if (w && sel && a[3:2] == 2'd1 && d[3]) begin
        m_ovf = 1'b0;
      end
    end
    #1;
    chk("tx", {31'h0, tx}, {31'h0, m_tx()});
    chk("tx_busy", {31'h0, tx_busy}, {31'h0, m_busy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b1);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b1);
  endtask

  initial begin
    logic [31:0] a_tab [5];
    int n;
    a_tab[0] = 32'h1000; a_tab[1] = 32'h1004; a_tab[2] = 32'h1008;
    a_tab[3] = 32'h100C; a_tab[4] = 32'h2000;

    cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b1);
    chk("reset_status", last_rdata, 32'h2);
    chk("reset_tx", {31'h0, tx}, 32'h1);

    st(32'h1000, 32'h55);
    idle(45);
    chk("after_55_status", last_rdata, 32'h2);

    for (int i = 1; i <= 6; i++) st(32'h1000, i);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b1);
    chk("full_ovf_status", last_rdata, 32'hD);
    idle(5 * FRAME + 5);
    cyc(1'b1, 1'b0, 32'h1004, 32'h8, 1'b1);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b1);
    chk("ovf_cleared", last_rdata, 32'h2);

    st(32'h2000, 32'h77);
    st(32'h1008, 32'h78);
    cyc(1'b0, 1'b1, 32'h2000, 32'h0, 1'b1);
    chk("unsel_read", last_rdata, 32'h0);
    idle(3);
    chk("unsel_no_frame", {31'h0, tx_busy}, 32'h0);

    st(32'h1000, 32'hA5);
    n = 0;
    while (!(m_busy && m_t == 14) && n < 100) begin idle(1); n++; end
    if (n >= 100) chk("wait_tmo_a5", 32'h0, 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("midrst_tx", {31'h0, tx}, 32'h1);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b1);
    chk("midrst_status", last_rdata, 32'h2);
    idle(FRAME + 10);

    for (int i = 0; i < 5; i++) st(32'h1000, 32'h30 + i);
    n = 0;
    while (!(m_busy && m_t == FRAME - 1 && q.size() == D) && n < 200) begin idle(1); n++; end
    if (n >= 200) chk("wait_tmo_ff", 32'h0, 32'h1);
    st(32'h1000, 32'hFF);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0, 1'b1);
    chk("pushpop_full", last_rdata, 32'h5);
    idle(5 * FRAME + 5);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a;
      a = a_tab[$urandom_range(0, 4)];
      cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, a,
          $urandom, ($urandom_range(0, 799) != 0));
    end
    idle(6 * FRAME);
    chk("final_idle_busy", {31'h0, tx_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
